// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR for unmapped active transfers, first-fault capture and
// saturating error counter. Optional err_irq output is built when DEFAULT_SLV_IRQ_EN is defined.
module ahb_default_slave #(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int ERR_CNT_WIDTH  = 8
) (
   input  logic                      hclk,
   input  logic                      hreset_n,
   input  logic                      hsel,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic [2:0]                hsize,
   input  logic                      hready,
   output logic                      hreadyout,
   output logic [1:0]                hresp,
   output logic                      err_valid,
   output logic [AHB_ADDR_WIDTH-1:0] err_addr,
   output logic                      err_write,
   output logic [2:0]                err_size,
   output logic                      err_overflow,
   output logic [ERR_CNT_WIDTH-1:0]  err_count,
   input  logic                      err_clr
`ifdef DEFAULT_SLV_IRQ_EN
   ,
   input  logic                      irq_en,
   output logic                      err_irq
`endif
);

   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_ERROR   = 2'b01;
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_ZERO = {ERR_CNT_WIDTH{1'b0}};
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE  = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX  = {ERR_CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } state_t;

   state_t                      r_state;
   logic                        r_hreadyout;
   logic [1:0]                  r_hresp;
   logic                        r_err_valid;
   logic [AHB_ADDR_WIDTH-1:0]   r_err_addr;
   logic                        r_err_write;
   logic [2:0]                  r_err_size;
   logic                        r_err_overflow;
   logic [ERR_CNT_WIDTH-1:0]    r_err_count;
   logic                        w_hit;
   logic                        w_load;

   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] cnt);
      if (cnt == CNT_MAX) begin
         return CNT_MAX;
      end else begin
         return cnt + CNT_ONE;
      end
   endfunction

   assign w_hit  = hsel && hready && ((htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ));
   // A clear on the same edge as a hit lets the hit become the new first capture.
   assign w_load = w_hit && (!r_err_valid || err_clr);

   // Response FSM with registered ready/response outputs.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_state     <= ST_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= RESP_OKAY;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_state     <= ST_ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= RESP_ERROR;
               end else begin
                  r_state     <= ST_IDLE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= RESP_OKAY;
               end
            end
            ST_ERR1: begin
               r_state     <= ST_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= RESP_ERROR;
            end
            ST_ERR2: begin
               if (w_hit) begin
                  r_state     <= ST_ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= RESP_ERROR;
               end else begin
                  r_state     <= ST_IDLE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= RESP_OKAY;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= RESP_OKAY;
            end
         endcase
      end
   end

   // First-fault address/direction/size capture.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_err_addr  <= {AHB_ADDR_WIDTH{1'b0}};
         r_err_write <= 1'b0;
         r_err_size  <= 3'b000;
      end else if (w_load) begin
         r_err_addr  <= haddr;
         r_err_write <= hwrite;
         r_err_size  <= hsize;
      end else begin
         r_err_addr  <= r_err_addr;
         r_err_write <= r_err_write;
         r_err_size  <= r_err_size;
      end
   end

   // Sticky valid/overflow flags and saturating error counter.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_err_valid    <= 1'b0;
         r_err_overflow <= 1'b0;
         r_err_count    <= CNT_ZERO;
      end else if (w_hit) begin
         r_err_valid    <= 1'b1;
         r_err_overflow <= !err_clr && (r_err_valid || r_err_overflow);
         r_err_count    <= err_clr ? CNT_ONE : sat_inc(r_err_count);
      end else if (err_clr) begin
         r_err_valid    <= 1'b0;
         r_err_overflow <= 1'b0;
         r_err_count    <= CNT_ZERO;
      end else begin
         r_err_valid    <= r_err_valid;
         r_err_overflow <= r_err_overflow;
         r_err_count    <= r_err_count;
      end
   end

`ifdef DEFAULT_SLV_IRQ_EN
   logic r_err_irq;

   // Level interrupt trails the sticky flags by one cycle.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_err_irq <= 1'b0;
      end else begin
         r_err_irq <= irq_en && (r_err_valid || r_err_overflow);
      end
   end

   assign err_irq = r_err_irq;
`endif

   assign hreadyout    = r_hreadyout;
   assign hresp        = r_hresp;
   assign err_valid    = r_err_valid;
   assign err_addr     = r_err_addr;
   assign err_write    = r_err_write;
   assign err_size     = r_err_size;
   assign err_overflow = r_err_overflow;
   assign err_count    = r_err_count;

endmodule

// File: tb/tb_ahb_default_slave.sv
// Bench for ahb_default_slave: directed literal checks plus randomized traffic compared every
// cycle against a behavioural model. Two instances cover 8-bit and 2-bit counters.
module tb_ahb_default_slave;

   logic        clk;
   logic        hreset_n;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic        hready;
   logic        err_clr;
   logic        other_rdy;
   logic        chk_on;

   logic        hreadyout, hreadyout2;
   logic [1:0]  hresp, hresp2;
   logic        err_valid, err_valid2;
   logic [31:0] err_addr, err_addr2;
   logic        err_write, err_write2;
   logic [2:0]  err_size, err_size2;
   logic        err_overflow, err_overflow2;
   logic [7:0]  err_count;
   logic [1:0]  err_count2;
`ifdef DEFAULT_SLV_IRQ_EN
   logic        irq_en;
   logic        err_irq, err_irq2;
`endif

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

   // Behavioural model: remaining error-response cycles plus capture state.
   int          m_left;
   logic        m_ready;
   logic        m_valid;
   logic [31:0] m_addr;
   logic        m_write;
   logic [2:0]  m_size;
   logic        m_ovf;
   int          m_cnt8;
   int          m_cnt2;
   logic        m_irq;
   logic        m_hit;

   assign hready = m_ready && other_rdy;
   assign m_hit  = hsel && hready && ((htrans == NSEQ) || (htrans == SEQ));

   ahb_default_slave #(.AHB_ADDR_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
      .hclk(clk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
      .err_valid(err_valid), .err_addr(err_addr), .err_write(err_write), .err_size(err_size),
      .err_overflow(err_overflow), .err_count(err_count), .err_clr(err_clr)
`ifdef DEFAULT_SLV_IRQ_EN
      , .irq_en(irq_en), .err_irq(err_irq)
`endif
   );

   ahb_default_slave #(.AHB_ADDR_WIDTH(32), .ERR_CNT_WIDTH(2)) dut2 (
      .hclk(clk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hready(hready), .hreadyout(hreadyout2), .hresp(hresp2),
      .err_valid(err_valid2), .err_addr(err_addr2), .err_write(err_write2), .err_size(err_size2),
      .err_overflow(err_overflow2), .err_count(err_count2), .err_clr(err_clr)
`ifdef DEFAULT_SLV_IRQ_EN
      , .irq_en(irq_en), .err_irq(err_irq2)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int next_left(input int left, input logic hit);
      if (left == 2) return 1;
      if (hit) return 2;
      return 0;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v < maxv) ? v + 1 : maxv;
   endfunction

   always @(posedge clk or negedge hreset_n) begin
      if (!hreset_n) begin
         m_left <= 0; m_ready <= 1'b1; m_valid <= 1'b0; m_addr <= 32'h0;
         m_write <= 1'b0; m_size <= 3'b000; m_ovf <= 1'b0; m_cnt8 <= 0; m_cnt2 <= 0;
         m_irq <= 1'b0;
      end else begin
         m_left  <= next_left(m_left, m_hit);
         m_ready <= (next_left(m_left, m_hit) != 2);
`ifdef DEFAULT_SLV_IRQ_EN
         m_irq   <= irq_en && (m_valid || m_ovf);
`endif
         if (m_hit) begin
            if (!m_valid || err_clr) begin
               m_addr <= haddr; m_write <= hwrite; m_size <= hsize;
            end
            m_valid <= 1'b1;
            m_ovf   <= err_clr ? 1'b0 : (m_valid || m_ovf);
            m_cnt8  <= err_clr ? 1 : sat(m_cnt8, 255);
            m_cnt2  <= err_clr ? 1 : sat(m_cnt2, 3);
         end else if (err_clr) begin
            m_valid <= 1'b0; m_ovf <= 1'b0; m_cnt8 <= 0; m_cnt2 <= 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("hreadyout", 64'(hreadyout), 64'(m_left != 2));
         chk("hresp", 64'(hresp), (m_left != 0) ? 64'd1 : 64'd0);
         chk("err_valid", 64'(err_valid), 64'(m_valid));
         chk("err_addr", 64'(err_addr), 64'(m_addr));
         chk("err_write", 64'(err_write), 64'(m_write));
         chk("err_size", 64'(err_size), 64'(m_size));
         chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
         chk("err_count", 64'(err_count), 64'(m_cnt8));
         chk("hreadyout2", 64'(hreadyout2), 64'(m_left != 2));
         chk("hresp2", 64'(hresp2), (m_left != 0) ? 64'd1 : 64'd0);
         chk("err_addr2", 64'(err_addr2), 64'(m_addr));
         chk("err_overflow2", 64'(err_overflow2), 64'(m_ovf));
         chk("err_count2", 64'(err_count2), 64'(m_cnt2));
`ifdef DEFAULT_SLV_IRQ_EN
         chk("err_irq", 64'(err_irq), 64'(m_irq));
         chk("err_irq2", 64'(err_irq2), 64'(m_irq));
`endif
      end
   end

   task automatic cyc(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [2:0] sz, input logic clr);
      hsel = sel; htrans = tr; haddr = a; hwrite = w; hsize = sz; err_clr = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic resp(input string nm, input logic rdy, input logic [1:0] rs);
      chk({nm, "_rdy"}, 64'(hreadyout), 64'(rdy));
      chk({nm, "_resp"}, 64'(hresp), 64'(rs));
   endtask

   initial begin
      hreset_n = 1'b0; hsel = 1'b0; htrans = IDLE; haddr = 32'h0; hwrite = 1'b0;
      hsize = 3'b000; err_clr = 1'b0; other_rdy = 1'b1; chk_on = 1'b0;
`ifdef DEFAULT_SLV_IRQ_EN
      irq_en = 1'b1;
`endif
      @(negedge clk); @(negedge clk);
      hreset_n = 1'b1; chk_on = 1'b1;
      resp("reset", 1'b1, 2'b00);
      chk("reset_count", 64'(err_count), 64'd0);

      // Single NONSEQ write hit
      cyc(1'b1, NSEQ, 32'h0000_0200, 1'b1, 3'b010, 1'b0);
      resp("hit1_err1", 1'b0, 2'b01);
`ifdef DEFAULT_SLV_IRQ_EN
      chk("irq_lag", 64'(err_irq), 64'd0);
`endif
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      resp("hit1_err2", 1'b1, 2'b01);
      chk("hit1_valid", 64'(err_valid), 64'd1);
      chk("hit1_addr", 64'(err_addr), 64'h200);
      chk("hit1_write", 64'(err_write), 64'd1);
      chk("hit1_size", 64'(err_size), 64'd2);
      chk("hit1_count", 64'(err_count), 64'd1);
`ifdef DEFAULT_SLV_IRQ_EN
      chk("irq_rise", 64'(err_irq), 64'd1);
`endif
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      resp("hit1_done", 1'b1, 2'b00);

      // IDLE / BUSY while selected
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b1);
      chk("clr_count", 64'(err_count), 64'd0);
      cyc(1'b1, IDLE, 32'h10, 1'b0, 3'b000, 1'b0);
      resp("idle_sel", 1'b1, 2'b00);
`ifdef DEFAULT_SLV_IRQ_EN
      chk("irq_fall", 64'(err_irq), 64'd0);
`endif
      cyc(1'b1, BUSY, 32'h14, 1'b1, 3'b010, 1'b0);
      resp("busy_sel", 1'b1, 2'b00);
      chk("busy_count", 64'(err_count), 64'd0);

      // Back-to-back hits, second sampled in ERR2
      cyc(1'b1, NSEQ, 32'h300, 1'b0, 3'b010, 1'b0);
      resp("b2b_a1", 1'b0, 2'b01);
      cyc(1'b1, NSEQ, 32'h304, 1'b0, 3'b010, 1'b0);
      resp("b2b_a2", 1'b1, 2'b01);
      cyc(1'b1, NSEQ, 32'h304, 1'b0, 3'b010, 1'b0);
      resp("b2b_b1", 1'b0, 2'b01);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      resp("b2b_b2", 1'b1, 2'b01);
      chk("b2b_addr", 64'(err_addr), 64'h300);
      chk("b2b_ovf", 64'(err_overflow), 64'd1);
      chk("b2b_count", 64'(err_count), 64'd2);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      resp("b2b_done", 1'b1, 2'b00);

      // Saturation of the 2-bit counter
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, SEQ, 32'h1000 + 32'(i * 4), 1'b0, 3'b010, 1'b0);
         cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      end
      chk("sat_count2", 64'(err_count2), 64'd3);
      chk("sat_count8", 64'(err_count), 64'd6);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      chk("sat_hold2", 64'(err_count2), 64'd3);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b1);
      chk("satclr_count2", 64'(err_count2), 64'd0);
      chk("satclr_valid", 64'(err_valid2), 64'd0);
      chk("satclr_ovf", 64'(err_overflow2), 64'd0);

      // Clear and hit on the same edge
      cyc(1'b1, NSEQ, 32'h200, 1'b0, 3'b001, 1'b0);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      cyc(1'b1, NSEQ, 32'h400, 1'b1, 3'b000, 1'b1);
      chk("clrhit_addr", 64'(err_addr), 64'h400);
      chk("clrhit_valid", 64'(err_valid), 64'd1);
      chk("clrhit_ovf", 64'(err_overflow), 64'd0);
      chk("clrhit_count", 64'(err_count), 64'd1);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);

      // Asynchronous reset in ERR1
      cyc(1'b1, NSEQ, 32'h500, 1'b0, 3'b010, 1'b0);
      resp("prerst", 1'b0, 2'b01);
      #1 hreset_n = 1'b0;
      #1;
      resp("rst_mid", 1'b1, 2'b00);
      chk("rst_valid", 64'(err_valid), 64'd0);
      chk("rst_addr", 64'(err_addr), 64'd0);
      chk("rst_count", 64'(err_count), 64'd0);
      chk("rst_ovf", 64'(err_overflow), 64'd0);
      hsel = 1'b0; htrans = IDLE;
      @(negedge clk);
      hreset_n = 1'b1;
      cyc(1'b1, NSEQ, 32'h600, 1'b1, 3'b001, 1'b0);
      resp("post_rst1", 1'b0, 2'b01);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
      resp("post_rst2", 1'b1, 2'b01);
      chk("post_rst_addr", 64'(err_addr), 64'h600);
      cyc(1'b0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         other_rdy = ($urandom_range(0, 9) != 0);
`ifdef DEFAULT_SLV_IRQ_EN
         if ($urandom_range(0, 49) == 0) irq_en = ~irq_en;
`endif
         if ($urandom_range(0, 399) == 0) begin
            #2 hreset_n = 1'b0;
            @(negedge clk);
            hreset_n = 1'b1;
         end
         cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 19) == 0));
      end

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ahb_default_slave.md
Name: ahb_default_slave

Overview:
AHB default slave that responds to every transfer the address decoders cannot map to a real slave. Its select input is the default-slave select output of each master-side decoder.
- Produces the AHB two-cycle ERROR response for active transfers and a zero-wait OKAY for IDLE/BUSY.
- Captures the first faulting transfer and counts decode errors, so software and debug can see them.

Parameters:
AHB_ADDR_WIDTH, 32, width of haddr and err_addr
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
hclk  input  1  bus clock, all state updates on rising edge
hreset_n  input  1  reset, asynchronous, active-low
hsel  input  1  default-slave select from decoder (default_slv_sel)
haddr  input  AHB_ADDR_WIDTH  transfer address
htrans  input  htrans_type  transfer type from AHB_package (IDLE/BUSY/NONSEQ/SEQ)
hwrite  input  1  transfer direction, 1 = write
hsize  input  3  transfer size
hready  input  1  bus-level ready; address phase is sampled only when high
hreadyout  output  1  slave ready
hresp  output  2  response: 2'b00 OKAY, 2'b01 ERROR
err_valid  output  1  sticky, a captured error is held
err_addr  output  AHB_ADDR_WIDTH  address of first captured error
err_write  output  1  hwrite of first captured error
err_size  output  3  hsize of first captured error
err_overflow  output  1  sticky, another error occurred while err_valid was set
err_count  output  ERR_CNT_WIDTH  saturating count of error transfers
err_clr  input  1  one-cycle pulse, clears capture, overflow and counter

Behaviour:
- Qualifying transfer ("hit"): hsel && hready && (htrans == NONSEQ || htrans == SEQ), sampled at the rising edge of hclk.
- Non-qualifying selected transfer (IDLE, BUSY): no state change; hreadyout=1, hresp=OKAY (zero wait).
- FSM states:
  - ST_IDLE: hreadyout=1, hresp=OKAY. A hit moves to ST_ERR1.
  - ST_ERR1: hreadyout=0, hresp=ERROR. Unconditionally moves to ST_ERR2. hready is low this cycle, so nothing is sampled.
  - ST_ERR2: hreadyout=1, hresp=ERROR. A hit (pipelined next transfer) moves to ST_ERR1; otherwise moves to ST_IDLE.
- Outputs are registered (Moore) from state. Response latency is one cycle after the address-phase hit; the ERROR response lasts exactly two cycles.
- Back-to-back hits: NONSEQ sampled in ST_ERR2 gives ERR1, ERR2, ERR1, ERR2 with no OKAY gap.
- Master cancel: if the master drives IDLE during ST_ERR2, the FSM returns to ST_IDLE with no further error.
- Capture, at the hit edge:
  - If err_valid=0: load err_addr/err_write/err_size and set err_valid.
  - If err_valid=1: keep the first capture and set err_overflow.
- Counter: err_count increments by 1 per hit and saturates at 2^ERR_CNT_WIDTH-1 with no wrap.
- err_clr: clears err_valid, err_overflow and err_count to 0 on the next edge.
  - err_clr and a hit on the same edge: the hit wins. The new transfer is captured, err_valid=1, err_overflow=0, err_count=1.
  - err_clr does not affect the FSM or the bus response.
- Reset (async, any time, including mid-ERROR): state=ST_IDLE, hreadyout=1, hresp=OKAY, err_valid=0, err_addr=0, err_write=0, err_size=0, err_overflow=0, err_count=0. The next hit after reset release is handled normally.
- hsel low in ST_IDLE: outputs stay OKAY/ready. The block never stalls a bus it is not selected on.

Optional Feature:
Macro DEFAULT_SLV_IRQ_EN.
- Defined: adds input irq_en (1) and output err_irq (1). err_irq is registered: err_irq <= irq_en && (err_valid || err_overflow). It asserts one cycle after err_valid rises, is level-held, deasserts one cycle after err_clr or irq_en low, and resets to 0.
- Not defined: both ports and the logic are absent; all other behaviour is identical.

Test Plan:
- NONSEQ hit, haddr=32'h0000_0200, hwrite=1, hsize=3'b010 -> next two cycles: hreadyout 0 then 1, hresp 01 both. Then err_valid=1, err_addr=32'h0000_0200, err_write=1, err_size=2, err_count=1.
- hsel=1 with htrans=IDLE, then BUSY -> hreadyout=1, hresp=00 every cycle; err_count stays 0.
- Two back-to-back NONSEQ hits (second sampled in ST_ERR2, haddr 0x300 then 0x304) -> ERR1,ERR2,ERR1,ERR2 with no OKAY gap. err_addr=0x300, err_overflow=1, err_count=2.
- ERR_CNT_WIDTH=2, six hits -> err_count reaches 3 and holds at 3. Then err_clr alone -> count 0, err_valid 0, err_overflow 0.
- err_clr on the same edge as a hit at haddr 0x400, with a prior capture at 0x200 -> err_addr=0x400, err_valid=1, err_overflow=0, err_count=1.
- hreset_n driven low during ST_ERR1 -> immediately hreadyout=1, hresp=00, all err_* zero. A hit after release gives a normal two-cycle ERROR. With DEFAULT_SLV_IRQ_EN and irq_en=1: err_irq rises one cycle after err_valid and falls one cycle after err_clr.
